// File: rtl/rom_prefetch_buffer.sv
// rom_prefetch_buffer
//   Prefetch buffer between the cartridge-ROM port of the 2600 core and the
//   QSPI flash controller. A small FIFO holds bytes streamed sequentially from
//   flash starting at cartridge address `base`. Core reads that land inside the
//   buffered window are served with one cycle of latency. A read of the byte
//   just past the window waits for the stream. Any other read stops the stream
//   and restarts it at the new address.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   rom_read, rom_addr  core read request (address held while rom_wait=1)
//   rom_data            registered byte for the last hit address
//   rom_wait            combinational stall back to the core
//   flash_addr          stream start address (FLASH_BASE + rom_addr)
//   flash_start_read    one-cycle pulse: start a stream at flash_addr
//   flash_stop_read     one-cycle pulse: abort the current stream
//   flash_stall_read    hold the flash clock (FIFO nearly full or window end)
//   flash_data(_ready)  byte from controller, captured on the rising edge of ready
//   flash_busy          controller is streaming or stopping
//   stat_hits/misses    only with ROM_PREFETCH_STATS_EN: saturating first-cycle
//                       hit and miss counters
//
// Build option: define ROM_PREFETCH_STATS_EN to add the statistics counters.
//
// state    | meaning
// IDLE     | no stream running, FIFO empty
// STREAM   | stream running, FIFO window base..base+count-1 valid
// STOPPING | stop issued, waiting for the controller to go idle
// RESTART  | issue a start at the address the core is now holding

module rom_prefetch_buffer #(
  parameter int          ADDR_BITS  = 12,
  parameter logic [23:0] FLASH_BASE = 24'h100000,
  parameter int          DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rom_read,
  input  logic [ADDR_BITS-1:0] rom_addr,
  output logic [7:0]           rom_data,
  output logic                 rom_wait,
  output logic [23:0]          flash_addr,
  output logic                 flash_start_read,
  output logic                 flash_stop_read,
  output logic                 flash_stall_read,
  input  logic [7:0]           flash_data,
  input  logic                 flash_data_ready,
  input  logic                 flash_busy
`ifdef ROM_PREFETCH_STATS_EN
  ,
  output logic [15:0]          stat_hits,
  output logic [15:0]          stat_misses
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, STREAM, STOPPING, RESTART} state_t;

  state_t               state, state_n;
  logic [7:0]           mem [DEPTH];
  logic [PW-1:0]        head, head_n, rd_idx, wr_idx;
  logic [CW-1:0]        count, count_n, pop;
  logic [ADDR_BITS-1:0] base, base_n, offset;
  logic [ADDR_BITS:0]   next_cap, next_cap_n;
  logic [23:0]          flash_addr_n;
  logic                 at_end, hit, pending, miss, rise, push, ready_q;
  logic                 start_n, stop_n, stall_n;

  // Offset wraps modulo the cartridge window; next_cap carries one extra bit so
  // a window ending at the last cartridge byte is seen as "stream exhausted".
  assign offset   = rom_addr - base;
  assign next_cap = {1'b0, base} + (ADDR_BITS+1)'(count);
  assign at_end   = next_cap[ADDR_BITS];
  assign hit      = rom_read && (offset < ADDR_BITS'(count));
  assign pending  = rom_read && (state == STREAM) && !hit && !at_end &&
                    (offset == ADDR_BITS'(count));
  assign miss     = rom_read && !hit && !pending;
  assign rise     = flash_data_ready && !ready_q;
  assign rom_wait = rst_n && rom_read && !hit;
  assign rd_idx   = head + PW'(offset);
  assign wr_idx   = head + PW'(count);

  always_comb begin
    state_n      = state;
    base_n       = base;
    count_n      = count;
    head_n       = head;
    flash_addr_n = flash_addr;
    start_n      = 1'b0;
    stop_n       = 1'b0;
    push         = 1'b0;
    pop          = '0;
    case (state)
      IDLE: begin
        if (miss && !flash_busy) begin
          start_n      = 1'b1;
          flash_addr_n = FLASH_BASE + 24'(rom_addr);
          base_n       = rom_addr;
          count_n      = '0;
          head_n       = '0;
          state_n      = STREAM;
        end
      end
      STREAM: begin
        if (miss) begin
          stop_n  = 1'b1;
          count_n = '0;
          head_n  = '0;
          state_n = STOPPING;
        end else begin
          // A pending read drops the whole window so the next captured byte
          // becomes the head; this also keeps a full FIFO from deadlocking.
          if (hit)
            pop = CW'(offset);
          else if (pending)
            pop = count;
          push    = rise && (count < CW'(DEPTH)) && !at_end;
          base_n  = base + ADDR_BITS'(pop);
          head_n  = head + PW'(pop);
          count_n = count - pop + CW'(push);
        end
      end
      STOPPING: begin
        if (!flash_busy)
          state_n = RESTART;
      end
      RESTART: begin
        if (!rom_read) begin
          state_n = IDLE;
        end else if (!flash_busy) begin
          start_n      = 1'b1;
          flash_addr_n = FLASH_BASE + 24'(rom_addr);
          base_n       = rom_addr;
          count_n      = '0;
          head_n       = '0;
          state_n      = STREAM;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign next_cap_n = {1'b0, base_n} + (ADDR_BITS+1)'(count_n);
  assign stall_n    = (state_n == STREAM) &&
                      ((count_n >= CW'(DEPTH - 1)) || next_cap_n[ADDR_BITS]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      base             <= '0;
      count            <= '0;
      head             <= '0;
      rom_data         <= 8'h00;
      flash_addr       <= FLASH_BASE;
      flash_start_read <= 1'b0;
      flash_stop_read  <= 1'b0;
      flash_stall_read <= 1'b0;
      ready_q          <= 1'b0;
    end else begin
      state            <= state_n;
      base             <= base_n;
      count            <= count_n;
      head             <= head_n;
      flash_addr       <= flash_addr_n;
      flash_start_read <= start_n;
      flash_stop_read  <= stop_n;
      flash_stall_read <= stall_n;
      ready_q          <= flash_data_ready;
      if (hit)
        rom_data <= mem[rd_idx];
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_idx] <= flash_data;
  end

`ifdef ROM_PREFETCH_STATS_EN
  // A read is "first-cycle" unless the previous cycle was the same read stalled.
  logic held_q, first_rd;
  assign first_rd = rom_read && !held_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_q      <= 1'b0;
      stat_hits   <= 16'h0000;
      stat_misses <= 16'h0000;
    end else begin
      held_q <= rom_wait;
      if (first_rd && hit && (stat_hits != 16'hFFFF))
        stat_hits <= stat_hits + 16'd1;
      if (first_rd && !hit && (stat_misses != 16'hFFFF))
        stat_misses <= stat_misses + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rom_prefetch_buffer.sv
// Testbench for rom_prefetch_buffer: a behavioural flash controller streams a
// fixed byte pattern; every completed core read is compared with the byte the
// cartridge image holds at that address.
module tb_rom_prefetch_buffer;

  localparam logic [23:0] FLASH_BASE = 24'h100000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rom_read;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_wait;
  logic [23:0] flash_addr;
  logic        flash_start_read, flash_stop_read, flash_stall_read;
  logic [7:0]  flash_data;
  logic        flash_data_ready, flash_busy;
`ifdef ROM_PREFETCH_STATS_EN
  logic [15:0] stat_hits, stat_misses;
`endif

  always #5 clk = ~clk;

  rom_prefetch_buffer #(.ADDR_BITS(12), .FLASH_BASE(FLASH_BASE), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .rom_read(rom_read), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_wait(rom_wait), .flash_addr(flash_addr),
    .flash_start_read(flash_start_read), .flash_stop_read(flash_stop_read),
    .flash_stall_read(flash_stall_read), .flash_data(flash_data),
    .flash_data_ready(flash_data_ready), .flash_busy(flash_busy)
`ifdef ROM_PREFETCH_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    logic [23:0] t;
    t = (a * 24'd13) ^ (a >> 8) ^ 24'h00005A;
    return t[7:0];
  endfunction

  // Flash controller model: reacts 2 time units after each rising edge.
  bit          streaming = 0;
  int          stop_cnt = 0;
  int          lat = 0;
  logic [23:0] faddr = '0;

  initial begin
    flash_data_ready = 1'b0;
    flash_busy       = 1'b0;
    flash_data       = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        streaming = 0; stop_cnt = 0; flash_data_ready = 1'b0;
      end else if (flash_stop_read) begin
        streaming = 0; stop_cnt = 2; flash_data_ready = 1'b0;
      end else if (flash_start_read) begin
        streaming = 1; faddr = flash_addr; lat = $urandom_range(0, 2);
        flash_data_ready = 1'b0;
      end else if (streaming) begin
        if (flash_data_ready)
          flash_data_ready = 1'b0;
        else if (lat > 0)
          lat--;
        else if (!flash_stall_read) begin
          flash_data = flash_byte(faddr);
          faddr++;
          flash_data_ready = 1'b1;
          lat = $urandom_range(0, 2);
        end
      end else if (stop_cnt > 0) begin
        stop_cnt--;
      end
      flash_busy = streaming || (stop_cnt > 0);
    end
  end

  // Pulse monitor, sampled mid-cycle.
  int          n_start = 0, n_stop = 0, n_excl_bad = 0, n_busy_start = 0;
  logic [23:0] last_start = '0;
  logic        busy_prev = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (flash_start_read) begin
        n_start++;
        last_start = flash_addr;
        if (busy_prev) n_busy_start++;
      end
      if (flash_stop_read) n_stop++;
      if (flash_start_read && flash_stop_read) n_excl_bad++;
    end
    busy_prev = flash_busy;
  end

  task automatic do_read(input logic [11:0] a, input int want_wait, input string tag);
    int n;
    @(negedge clk);
    rom_read = 1'b1;
    rom_addr = a;
    #1;
    if (want_wait >= 0) chk({tag, "_first_wait"}, rom_wait, want_wait);
    n = 0;
    while (rom_wait && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (rom_wait) chk({tag, "_timeout"}, rom_wait, 0);
    @(posedge clk);
    #1;
    chk({tag, "_data"}, rom_data, flash_byte(FLASH_BASE + 24'(a)));
    rom_read = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rom_data"}, rom_data, 8'h00);
    chk({tag, "_rom_wait"}, rom_wait, 1'b0);
    chk({tag, "_start"}, flash_start_read, 1'b0);
    chk({tag, "_stop"}, flash_stop_read, 1'b0);
    chk({tag, "_stall"}, flash_stall_read, 1'b0);
    chk({tag, "_flash_addr"}, flash_addr, FLASH_BASE);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s0, p0;
    logic [11:0] cur;
    rst_n    = 1'b0;
    rom_read = 1'b1;
    rom_addr = 12'h0AB;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rom_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // 1: cold read near the end of the window
    s0 = n_start;
    do_read(12'hFFC, 1, "t1");
    chk("t1_starts", n_start - s0, 1);
    chk("t1_start_addr", last_start, 24'h100FFC);

    // 2: sequential run from a clean reset
    pulse_reset();
    s0 = n_start; p0 = n_stop;
    for (int a = 0; a < 16; a++) do_read(12'(a), -1, "t2");
    chk("t2_starts", n_start - s0, 1);
    chk("t2_stops", n_stop - p0, 0);
    repeat (20) @(negedge clk);
    chk("t2_stall_full", flash_stall_read, 1'b1);
    do_read(12'h011, 0, "t2_window");
    chk("t2_stops_after", n_stop - p0, 0);

    // 3: backwards jump forces stop and restart
    s0 = n_start; p0 = n_stop;
    do_read(12'h004, 1, "t3");
    chk("t3_stops", n_stop - p0, 1);
    chk("t3_starts", n_start - s0, 1);
    chk("t3_start_addr", last_start, 24'h100004);

    // 4: repeated reads of one address
    do_read(12'h123, 1, "t4_fill");
    s0 = n_start; p0 = n_stop;
    repeat (4) do_read(12'h123, 0, "t4_repeat");
    chk("t4_starts", n_start - s0, 0);
    chk("t4_stops", n_stop - p0, 0);

    // 5: stream reaches the end of the window, then wraps to 0
    do_read(12'hFFD, -1, "t5_seq");
    do_read(12'hFFE, -1, "t5_seq");
    do_read(12'hFFF, -1, "t5_seq");
    repeat (10) @(negedge clk);
    chk("t5_stall_end", flash_stall_read, 1'b1);
    s0 = n_start; p0 = n_stop;
    do_read(12'h000, 1, "t5_wrap");
    chk("t5_stops", n_stop - p0, 1);
    chk("t5_starts", n_start - s0, 1);
    chk("t5_start_addr", last_start, 24'h100000);

    // 6: reset mid-stream
    do_read(12'h200, -1, "t6_pre");
    repeat (3) @(negedge clk);
    rst_n    = 1'b0;
    rom_read = 1'b1;
    rom_addr = 12'h201;
    @(posedge clk);
    #1;
    check_reset_outputs("t6_reset");
    @(negedge clk);
    rom_read = 1'b0;
    rst_n    = 1'b1;
    s0 = n_start;
    do_read(12'h345, 1, "t6_cold");
    chk("t6_starts", n_start - s0, 1);
    chk("t6_start_addr", last_start, 24'h100345);

    // Randomised mix of sequential, repeated, short-skip and random reads
    cur = 12'h3F0;
    for (int i = 0; i < 60; i++) begin
      int c;
      c = $urandom_range(0, 9);
      if (c < 5)      cur = cur + 12'd1;
      else if (c < 7) cur = cur;
      else if (c < 8) cur = cur + 12'($urandom_range(2, 3));
      else            cur = 12'($urandom_range(0, 4095));
      if (i % 15 == 7) cur = 12'hFFE;
      do_read(cur, -1, "rnd");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    chk("start_stop_exclusive", n_excl_bad, 0);
    chk("start_while_busy", n_busy_start, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
